// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: PC handshake, instruction-memory port and decode-side FIFO head.
// The fetch_unit drives the master modport; the PC register, memory and decoder sit on slave.
interface fetch_unit_if;
  logic [15:0] pc_addr;
  logic [15:0] next_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  pc_addr, imem_rdata, imem_rvalid, redirect, redirect_target, instr_ready,
    output next_pc, imem_req, imem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output pc_addr, imem_rdata, imem_rvalid, redirect, redirect_target, instr_ready,
    input  next_pc, imem_req, imem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, small instruction FIFO, redirect flush.
// Define FETCH_PERF_EN to add the saturating perf_instr_count output (pops since reset).
module fetch_unit #(
  parameter int unsigned PC_STEP    = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  perf_instr_count
`endif
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UsedW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [15:0]       data_q [FIFO_DEPTH];
  logic [15:0]       pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [15:0]       req_addr_q;

  logic              busy, pop, push, issue, head_valid;
  logic [UsedW-1:0]  used;

  // Datapath handshakes shared by the FSM and the FIFO
  always_comb begin
    busy       = (state_q != StIdle);
    head_valid = ~reset & (count_q != '0);
    pop        = head_valid & bus.instr_ready & ~bus.redirect;
    push       = ~reset & ~bus.redirect & (state_q == StWait) & bus.imem_rvalid;
    // The head popped this cycle frees its slot, which keeps back-to-back fetch going
    used       = UsedW'(count_q) + UsedW'(busy) - UsedW'(pop);
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      // An outstanding fetch becomes stale unless its response lands this very cycle
      state_d = (busy & ~bus.imem_rvalid) ? StDrop : StIdle;
    end else if (issue) begin
      state_d = StWait;
    end else if (busy & bus.imem_rvalid) begin
      state_d = StIdle;
    end
  end

  // FSM outputs
  always_comb begin
    issue = ~reset & ~bus.redirect & (used < UsedW'(FIFO_DEPTH));
    unique case (state_q)
      StIdle:  issue = issue;
      StWait,
      StDrop:  issue = issue & bus.imem_rvalid;
      default: issue = 1'b0;
    endcase

    bus.imem_req  = issue;
    bus.imem_addr = reset ? 16'h0000 : bus.pc_addr;
    if (reset) begin
      bus.next_pc = 16'h0000;
    end else if (bus.redirect) begin
      bus.next_pc = bus.redirect_target;
    end else if (issue) begin
      bus.next_pc = bus.pc_addr + 16'(PC_STEP);
    end else begin
      bus.next_pc = bus.pc_addr;
    end

    bus.instr_valid = head_valid;
    bus.instr       = data_q[rd_ptr_q];
    bus.instr_pc    = pc_q[rd_ptr_q];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset || bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage and the address of the request in flight
  always_ff @(posedge clock) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.imem_rdata;
      pc_q[wr_ptr_q]   <= req_addr_q;
    end
    if (issue) begin
      req_addr_q <= bus.pc_addr;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= 16'h0000;
    end else if (pop && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_instr_count = perf_q;
`endif

endmodule
